// File: rtl/adder_arbiter.sv
// adder_arbiter: two-requester arbiter and sequencer in front of one shared
// 4-bit ripple-carry adder. The winner's operands are captured into opa/opb.
// The adder then runs from those registers, and the sum and carry are
// returned with a one-cycle done pulse to the winner.
//
// Build option: define ADDER_ARBITER_FIXED_PRIO_EN for fixed priority.
// In that mode requester 0 always wins a tie and requester 1 can starve.
// When it is undefined (the default), ties alternate round-robin on the
// most recent winner.

// Plain 4-bit ripple-carry adder; the sum wraps modulo 16 and no carry port is
// exposed, so the carry is recovered by the caller from the operands.
module adder_ripple (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] s
);

  // c[i] is the carry into bit i; the carry out of bit 3 is not needed here
  logic [3:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign s[i] = a[i] ^ b[i] ^ c[i];
    if (i < 3) begin : g_carry
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

endmodule

module adder_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic       req1,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  output logic       done0,
  output logic       done1,
  output logic [3:0] res,
  output logic       cout,
  output logic       busy,
  output logic       gnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state_q;
  logic [3:0] opa_q;
  logic [3:0] opb_q;
  logic [3:0] res_q;
  logic       cout_q;
  logic       done0_q;
  logic       done1_q;
  logic       busy_q;
  logic       gnt_q;
  logic       last_q;

  logic [3:0] q;
  logic       any_req;
  logic       win_d;
  logic [3:0] wa_d;
  logic [3:0] wb_d;

  // Unsigned 4-bit add overflowed exactly when the wrapped sum is below an operand
  function automatic logic carry_out(input logic [3:0] sum, input logic [3:0] op);
    return (sum < op);
  endfunction

  // Shared adder, always fed from the registered operands
  adder_ripple u_adder (opa_q, opb_q, q);

  // Pick the winner among the current requests and steer its operands
  always_comb begin
    any_req = req0 | req1;
`ifdef ADDER_ARBITER_FIXED_PRIO_EN
    // Requester 0 takes every tie; history is not consulted
    win_d = ~req0;
`else
    // On a tie the requester that did not win last time goes next
    if (req0 && req1) begin
      win_d = ~last_q;
    end else begin
      win_d = ~req0;
    end
`endif
    wa_d = win_d ? a1 : a0;
    wb_d = win_d ? b1 : b0;
  end

  // Sequencer: IDLE grants, CALC captures the sum, RESP retires the done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= 4'd0;
      opb_q   <= 4'd0;
      res_q   <= 4'd0;
      cout_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      busy_q  <= 1'b0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            opa_q   <= wa_d;
            opb_q   <= wb_d;
            gnt_q   <= win_d;
            last_q  <= win_d;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          res_q   <= q;
          cout_q  <= carry_out(q, opa_q);
          done0_q <= ~gnt_q;
          done1_q <= gnt_q;
          state_q <= RESP;
        end
        RESP: begin
          // Requests are deliberately ignored here; a held req re-arbitrates in IDLE
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign done0 = done0_q;
  assign done1 = done1_q;
  assign res   = res_q;
  assign cout  = cout_q;
  assign busy  = busy_q;
  assign gnt   = gnt_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: a transaction-timeline model checks
// every cycle, and directed scenarios pin literal results and timing.
`timescale 1ns/1ps
module tb_adder_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [3:0] a0 = 4'd0, b0 = 4'd0, a1 = 4'd0, b1 = 4'd0;
  logic       done0, done1, cout, busy, gnt;
  logic [3:0] res;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  adder_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .done0(done0), .done1(done1),
    .res(res), .cout(cout), .busy(busy), .gnt(gnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required done");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timeline model: a grant at edge g means busy after edges g and g+1,
  // done/result after edge g+1, next arbitration no earlier than edge g+3.
  int         m_ec = 0;
  int         m_g = -10;
  int         m_who = 0;
  int         m_last = 1;
  int         m_a = 0, m_b = 0;
  int         m_res = 0, m_cout = 0, m_gnt = 0;

  task automatic model_loop();
    int w;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_ec = 0; m_g = -10; m_last = 1; m_res = 0; m_cout = 0; m_gnt = 0; m_who = 0;
        chk("m_rst_busy", busy, 0);
        chk("m_rst_done0", done0, 0);
        chk("m_rst_done1", done1, 0);
        chk("m_rst_res", res, 0);
        chk("m_rst_cout", cout, 0);
        chk("m_rst_gnt", gnt, 0);
      end else begin
        if (m_ec == m_g) m_gnt = m_who;
        if (m_ec == m_g + 1) begin
          m_res  = (m_a + m_b) % 16;
          m_cout = ((m_a + m_b) > 15) ? 1 : 0;
        end
        chk("m_busy", busy, ((m_ec - m_g) == 0 || (m_ec - m_g) == 1) ? 1 : 0);
        chk("m_done0", done0, (m_ec == m_g + 1 && m_who == 0) ? 1 : 0);
        chk("m_done1", done1, (m_ec == m_g + 1 && m_who == 1) ? 1 : 0);
        chk("m_res", res, 8'(m_res));
        chk("m_cout", cout, 8'(m_cout));
        chk("m_gnt", gnt, 8'(m_gnt));
        // Decide what the coming edge does
        if ((m_ec + 1 >= m_g + 3) && (req0 || req1)) begin
          if (req0 && req1) begin
`ifdef ADDER_ARBITER_FIXED_PRIO_EN
            w = 0;
`else
            w = 1 - m_last;
`endif
          end else begin
            w = req0 ? 0 : 1;
          end
          m_g = m_ec + 1; m_who = w; m_last = w;
          m_a = (w == 0) ? int'(a0) : int'(a1);
          m_b = (w == 0) ? int'(b0) : int'(b1);
        end
        m_ec++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input bit who, input int budget, output int at);
    bit seen;
    seen = 1'b0;
    at = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if ((who ? done1 : done0) === 1'b1) begin
        seen = 1'b1;
        at = cyc;
      end
    end
    chk(who ? "done1_seen" : "done0_seen", 8'(seen), 1);
  endtask

  int t0, t1, t2;
  int who_l[$];
  int at_l[$];
  int exp_who;

  initial begin
    fork
      model_loop();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_done0", done0, 0);
    chk("rst_done1", done1, 0);
    chk("rst_res", res, 0);
    chk("rst_cout", cout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gnt", gnt, 0);

    // Single requester 0: 1+1
    step();
    req0 = 1'b1; a0 = 4'd1; b0 = 4'd1;
    t0 = cyc;
    wait_done(0, 6, t1);
    chk("r0_res", res, 8'h2);
    chk("r0_cout", cout, 0);
    chk("r0_gnt", gnt, 0);
    chk("r0_latency", 8'(t1 - t0), 2);
    step();
    req0 = 1'b0;

    // Requester 1: F+F then 1+2
    req1 = 1'b1; a1 = 4'hF; b1 = 4'hF;
    wait_done(1, 6, t1);
    chk("r1_res_ff", res, 8'hE);
    chk("r1_cout_ff", cout, 1);
    chk("r1_gnt", gnt, 1);
    step();
    a1 = 4'd1; b1 = 4'd2;
    wait_done(1, 6, t1);
    chk("r1_res_12", res, 8'h3);
    chk("r1_cout_12", cout, 0);
    step();
    req1 = 1'b0;

    // Simultaneous requests right after reset: requester 0 first
    rst = 1'b1;
    step();
    rst = 1'b0;
    req0 = 1'b1; a0 = 4'd0; b0 = 4'd1;
    req1 = 1'b1; a1 = 4'd1; b1 = 4'd1;
    wait_done(0, 6, t1);
    chk("tie_res0", res, 8'h1);
    chk("tie_gnt0", gnt, 0);
    step();
    req0 = 1'b0;
    wait_done(1, 6, t2);
    chk("tie_res1", res, 8'h2);
    chk("tie_gnt1", gnt, 1);
    chk("tie_spacing", 8'(t2 - t1), 3);
    step();
    req1 = 1'b0;
    repeat (3) step();

    // Both held continuously
    req0 = 1'b1; a0 = 4'd3; b0 = 4'd4;
    req1 = 1'b1; a1 = 4'd9; b1 = 4'd9;
    who_l.delete();
    at_l.delete();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done0 === 1'b1) begin who_l.push_back(0); at_l.push_back(cyc); end
      if (done1 === 1'b1) begin who_l.push_back(1); at_l.push_back(cyc); end
    end
    chk("hold_count", 8'(who_l.size()), 4);
    for (int k = 0; k < 4 && k < who_l.size(); k++) begin
`ifdef ADDER_ARBITER_FIXED_PRIO_EN
      exp_who = 0;
`else
      exp_who = k % 2;
`endif
      chk("hold_who", 8'(who_l[k]), 8'(exp_who));
      if (k > 0) chk("hold_spacing", 8'(at_l[k] - at_l[k-1]), 3);
    end
    step();

`ifdef ADDER_ARBITER_FIXED_PRIO_EN
    // Requester 1 is served once requester 0 goes away
    req0 = 1'b0;
    wait_done(1, 8, t1);
    chk("fp_res1", res, 8'h2);
    chk("fp_cout1", cout, 1);
    step();
`endif
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) step();

    // Reset while in CALC discards the operation
    req0 = 1'b1; a0 = 4'hF; b0 = 4'hF;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rc_busy", busy, 0);
    chk("rc_done0", done0, 0);
    chk("rc_res", res, 0);
    chk("rc_cout", cout, 0);
    step();
    rst = 1'b0;
    wait_done(0, 6, t1);
    chk("rc_res_after", res, 8'hE);
    chk("rc_cout_after", cout, 1);
    chk("rc_gnt_after", gnt, 0);
    step();
    req0 = 1'b0;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
